// File: rtl/prio_intr_ctrl_if.sv
// prio_intr_ctrl_if: request/mask/handshake bundle between peripherals, host and prio_intr_ctrl
// Signals:
//   req        NUM_BUS*NUM_CH  request lines, bus b channel c at bit b*NUM_CH+c
//   mask_we    1               mask register write strobe
//   mask_wdata NUM_CH          new mask value, 1 = channel masked on all buses
//   ack        1               host acknowledge of the current interrupt
//   irq        1               interrupt outstanding
//   irq_bus    BUS_W           bus of the granted request
//   irq_id     ID_W            channel of the granted request
//   bus_pend   NUM_BUS         per-bus OR of unmasked pending bits
//   mask_q     NUM_CH          current mask register
// Modports: master = host/peripheral side, slave = controller side
interface prio_intr_ctrl_if #(
  parameter int NUM_CH = 9,
  parameter int NUM_BUS = 3,
  parameter int ID_W = $clog2(NUM_CH),
  parameter int BUS_W = (NUM_BUS > 1) ? $clog2(NUM_BUS) : 1
);
  logic [NUM_BUS*NUM_CH-1:0] req;
  logic mask_we;
  logic [NUM_CH-1:0] mask_wdata;
  logic ack;
  logic irq;
  logic [BUS_W-1:0] irq_bus;
  logic [ID_W-1:0] irq_id;
  logic [NUM_BUS-1:0] bus_pend;
  logic [NUM_CH-1:0] mask_q;
  modport master (
    output req, mask_we, mask_wdata, ack,
    input irq, irq_bus, irq_id, bus_pend, mask_q
  );
  modport slave (
    input req, mask_we, mask_wdata, ack,
    output irq, irq_bus, irq_id, bus_pend, mask_q
  );
endinterface

// File: rtl/prio_intr_ctrl.sv
// prio_intr_ctrl: pending/mask/priority interrupt controller with irq/ack handshake
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    prio_intr_ctrl_if.slave (req, mask_we, mask_wdata, ack in; irq, irq_bus, irq_id, bus_pend, mask_q out)
// Macro PRIO_INTR_EDGE_EN: pending bits set on rising edges of req instead of levels.
module prio_intr_ctrl #(
  parameter int NUM_CH = 9,
  parameter int NUM_BUS = 3,
  parameter int ID_W = $clog2(NUM_CH),
  parameter int BUS_W = (NUM_BUS > 1) ? $clog2(NUM_BUS) : 1
) (
  input logic clk,
  input logic rst_n,
  prio_intr_ctrl_if.slave bus
);
  localparam int N = NUM_BUS * NUM_CH;
  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;
  state_t r_state;
  logic [N-1:0] r_pend, w_elig, w_clr, w_set, w_next;
  logic [NUM_CH-1:0] r_mask;
  logic [NUM_BUS-1:0] r_bus_pend, w_bus_pend;
  logic r_irq, w_ack;
  logic [BUS_W-1:0] r_irq_bus, w_bus;
  logic [ID_W-1:0] r_irq_id, w_id;
  assign w_elig = r_pend & ~{NUM_BUS{r_mask}};
  assign w_ack = (r_state == WAIT) && bus.ack;
  assign w_clr = w_ack ? (N'(1) << (int'(r_irq_bus) * NUM_CH + int'(r_irq_id))) : '0;
`ifdef PRIO_INTR_EDGE_EN
  logic [N-1:0] r_req_q;
  assign w_set = bus.req & ~r_req_q;
  // set after clear so an edge arriving in the ack cycle is not lost
  assign w_next = (r_pend & ~w_clr) | w_set;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_req_q <= '0;
    else r_req_q <= bus.req;
`else
  assign w_set = bus.req;
  assign w_next = (r_pend | w_set) & ~w_clr;
`endif
  // descending scan so the last hit is the lowest bus, then lowest channel
  always_comb begin
    w_bus = '0;
    w_id = '0;
    for (int b = NUM_BUS - 1; b >= 0; b--)
      for (int c = NUM_CH - 1; c >= 0; c--)
        if (w_elig[b*NUM_CH+c]) begin
          w_bus = BUS_W'(b);
          w_id = ID_W'(c);
        end
  end
  always_comb begin
    w_bus_pend = '0;
    for (int b = 0; b < NUM_BUS; b++) w_bus_pend[b] = |w_elig[b*NUM_CH +: NUM_CH];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend <= '0;
      r_mask <= '0;
      r_bus_pend <= '0;
      r_irq <= 1'b0;
      r_irq_bus <= '0;
      r_irq_id <= '0;
    end else begin
      r_pend <= w_next;
      r_bus_pend <= w_bus_pend;
      if (bus.mask_we) r_mask <= bus.mask_wdata;
      case (r_state)
        IDLE:
          if (|w_elig) begin
            r_irq <= 1'b1;
            r_irq_bus <= w_bus;
            r_irq_id <= w_id;
            r_state <= WAIT;
          end
        WAIT:
          if (bus.ack) begin
            r_irq <= 1'b0;
            r_state <= GAP;
          end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.irq = r_irq;
  assign bus.irq_bus = r_irq_bus;
  assign bus.irq_id = r_irq_id;
  assign bus.bus_pend = r_bus_pend;
  assign bus.mask_q = r_mask;
endmodule

// File: doc/prio_intr_ctrl.md
Name: prio_intr_ctrl

Overview:
- Parametrised, clocked successor to the combinational 9-channel, 3-bus priority interrupt decoder.
- Latches per-bus/per-channel requests into a pending array and applies a per-channel mask.
- Arbitrates by fixed bus priority, then lowest channel index.
- Issues one encoded interrupt at a time under an irq/ack handshake; sits between peripheral request lines and the host interrupt input.

Parameters:
- NUM_CH, 9, channels per bus (2..32)
- NUM_BUS, 3, request buses; bus 0 has highest priority (1..4)
- ID_W, $clog2(NUM_CH), width of the channel id
- BUS_W, $clog2(NUM_BUS) min 1, width of the bus id

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_BUS*NUM_CH  request lines; bus b, channel c at bit b*NUM_CH+c
- mask_we  in  1  write strobe for the mask register
- mask_wdata  in  NUM_CH  new mask value; 1 = channel masked on all buses
- ack  in  1  host acknowledge of the current interrupt
- irq  out  1  interrupt outstanding
- irq_bus  out  BUS_W  bus of the granted request
- irq_id  out  ID_W  channel of the granted request
- bus_pend  out  NUM_BUS  per bus: OR of unmasked pending bits (registered)
- mask_q  out  NUM_CH  current mask register

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (async assert, sync release) clears:
  - pend = 0, mask_q = 0, bus_pend = 0
  - irq = 0, irq_bus = 0, irq_id = 0
  - state = IDLE
- Reset mid-operation drops any outstanding irq immediately; no ack is required afterwards.
- Pending (level mode): at each edge, pend[i] <= (pend[i] & ~clr[i]) | (req[i] & ~clr[i]).
  - clr is one-hot for the acknowledged bit and is asserted only on a WAIT-state ack cycle.
  - On the same bit, clear wins; a request still high re-sets the bit on the next edge.
- Eligible vector: elig = pend & ~{NUM_BUS{mask_q}}.
  - Masked pending bits are retained and become eligible when unmasked.
- Mask: mask_q <= mask_wdata on an edge with mask_we = 1. A mask write during WAIT does not revoke the current grant.
- Arbitration (combinational on elig):
  - Lowest bus index containing any eligible bit wins.
  - Within that bus, lowest channel index wins.
- FSM:
  - IDLE: if elig != 0, register the winner into irq_bus/irq_id, set irq = 1, go to WAIT. Otherwise stay in IDLE.
  - WAIT: irq, irq_bus and irq_id are held stable regardless of req or mask changes. On ack = 1, clear the pend bit of the granted request, set irq = 0, go to GAP.
  - GAP: one cycle with irq = 0, then IDLE. This guarantees at least one low cycle of irq between grants.
- ack outside WAIT is ignored.
- Latency:
  - req sampled high at edge E0 sets pend after E0.
  - irq rises after E1 (2 edges).
  - With back-to-back pending requests, the next irq rises 2 edges after the ack edge.
- bus_pend is registered from elig every cycle, independent of FSM state.
- Out-of-range encodings (NUM_CH or NUM_BUS not a power of 2) are never produced.

Optional Feature:
- Macro: PRIO_INTR_EDGE_EN.
- Defined: pending bits set only on a rising edge of req.
  - A 1-deep req_q register per bit is added; req_q resets to 0.
  - set[i] = req[i] & ~req_q[i].
  - If a set and a clear of the same bit occur in the same cycle, set wins, so no new event is lost.
  - A level held high after ack does not re-trigger.
- Undefined: level mode as above; no req_q register.

Test Plan:
- Reset check (NUM_CH = 9, NUM_BUS = 3): assert rst_n = 0 mid-WAIT -> irq, irq_bus, irq_id, bus_pend and mask_q all 0 immediately; after release, no irq without req.
- Single request: req bit 13 (bus 1, ch 4) pulsed high at E0 -> irq = 1 after E1 with irq_bus = 1, irq_id = 4; bus_pend = 3'b010; ack -> irq = 0 for the GAP cycle, then stays 0.
- Priority: req bits 2, 9+0 and 18+1 set together -> grants in order (bus 0, ch 2), (bus 1, ch 0), (bus 2, ch 1), with one ack per grant and one irq-low cycle between grants.
- Mask: mask_wdata = 9'h004 written, then req bit 2 high -> no irq, bus_pend = 0; mask cleared -> irq with bus 0, ch 2 two edges later.
- Level re-trigger: hold req bit 0 high through ack -> in level mode irq reasserts (bus 0, ch 0) after GAP. With PRIO_INTR_EDGE_EN: no reassert until req falls and rises again.
- Simultaneous edge and ack (PRIO_INTR_EDGE_EN): rising edge on the granted bit in the ack cycle -> bit remains pending and is granted again.
